// File: rtl/exc_pkg.sv
// ---------------------------------------------------------------------------
// exc_pkg
//   Shared definitions for the exception/interrupt sequencer of the
//   multi-cycle MIPS core: sequencer state encoding, cause codes written to
//   the cause output, and the default handler vectors.
//   No ports (package).
// ---------------------------------------------------------------------------
package exc_pkg;

   localparam int DEF_WIDTH = 32;

   // Entry sequence: RUN -> SAVE (EPC load) -> VECTOR (PC redirect) -> KERNEL.
   typedef enum logic [1:0] {
      RUN    = 2'd0,
      SAVE   = 2'd1,
      VECTOR = 2'd2,
      KERNEL = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      CAUSE_NONE  = 2'b00,
      CAUSE_IRQ   = 2'b01,
      CAUSE_UNDEF = 2'b10
   } cause_t;

   localparam logic [31:0] DEF_IRQ_VECTOR = 32'h8000_0004;
   localparam logic [31:0] DEF_EXC_VECTOR = 32'h8000_0008;

endpackage

// File: rtl/irq_pending_latch.sv
// ---------------------------------------------------------------------------
// irq_pending_latch
//   Remembers a level timer interrupt until the sequencer acknowledges it.
//   The stored flag is set on any cycle irq is high and cleared on ack unless
//   irq is still high that cycle. The mask hides the flag from the sequencer
//   (handler running) without losing it.
// Ports
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-high reset
//   irq    in   level interrupt request
//   ack    in   interrupt accepted this cycle
//   mask   in   1 = interrupts not currently takeable
//   pend   out  pending and unmasked
// ---------------------------------------------------------------------------
module irq_pending_latch (
   input  logic clk,
   input  logic reset,
   input  logic irq,
   input  logic ack,
   input  logic mask,
   output logic pend
);

   logic pend_q;

   // NOTE: clocked state is always written with non-blocking assignments so
   // every flop samples the pre-edge values of its neighbours.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_q <= 1'b0;
      end else if (irq) begin
         pend_q <= 1'b1;          // set wins over a same-cycle ack
      end else if (ack) begin
         pend_q <= 1'b0;
      end
   end

   assign pend = pend_q & ~mask;

endmodule

// File: rtl/exception_ctrl.sv
// ---------------------------------------------------------------------------
// exception_ctrl
//   Exception/interrupt sequencer for the multi-cycle MIPS core. On an
//   undefined instruction or an accepted timer IRQ it saves the resume PC
//   into EPC, redirects the PC to the handler vector and enters kernel mode;
//   eret (jr $k0) returns to user mode. The handler is non-re-entrant.
// Ports
//   clk           in   rising-edge clock
//   reset         in   asynchronous active-high reset
//   irq           in   level interrupt request from timer
//   inst_done     in   pulse on the final cycle of the current instruction
//   undef_inst    in   decode pulse: opcode/funct not recognised
//   pc_now        in   PC of the instruction in flight
//   pc_next       in   PC the core would fetch next
//   eret          in   jr $k0 retiring this cycle
//   cpu_hold      out  core FSM must hold in fetch
//   flush         out  abort in-flight instruction
//   epc_write     out  EPC load enable
//   epc_data      out  value to load into EPC
//   exc_pc_write  out  force PC load
//   exc_pc        out  handler vector
//   kernel_mode   out  handler running (PC[31] supervisor bit)
//   cause         out  00 none, 01 IRQ, 10 UNDEF; held until eret
//   irq_ack       out  one-cycle pulse when the IRQ is accepted
// ---------------------------------------------------------------------------
module exception_ctrl
   import exc_pkg::*;
#(
   parameter int               WIDTH      = DEF_WIDTH,
   parameter logic [WIDTH-1:0] IRQ_VECTOR = WIDTH'(DEF_IRQ_VECTOR),
   parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(DEF_EXC_VECTOR)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             irq,
   input  logic             inst_done,
   input  logic             undef_inst,
   input  logic [WIDTH-1:0] pc_now,
   input  logic [WIDTH-1:0] pc_next,
   input  logic             eret,
   output logic             cpu_hold,
   output logic             flush,
   output logic             epc_write,
   output logic [WIDTH-1:0] epc_data,
   output logic             exc_pc_write,
   output logic [WIDTH-1:0] exc_pc,
   output logic             kernel_mode,
   output logic [1:0]       cause,
   output logic             irq_ack
);

   state_t           state, state_next;
   cause_t           cause_q;
   logic             kernel_q;
   logic [WIDTH-1:0] epc_q;
   logic [WIDTH-1:0] exc_pc_q;
   logic             irq_pend;
   logic             take_undef;
   logic             take_irq;

   irq_pending_latch u_irq_pending_latch (
      .clk   (clk),
      .reset (reset),
      .irq   (irq),
      .ack   (irq_ack),
      .mask  (kernel_q),
      .pend  (irq_pend)
   );

   // NOTE: every signal driven here gets a default first, so no path through
   // the case leaves it unassigned and no latch is inferred.
   always_comb begin
      state_next = state;
      take_undef = 1'b0;
      take_irq   = 1'b0;
      case (state)
         RUN: begin
            // An undefined instruction outranks a pending IRQ; the IRQ stays
            // pending and is taken after the handler returns.
            if (undef_inst) begin
               take_undef = 1'b1;
               state_next = SAVE;
            end else if (inst_done && irq_pend) begin
               take_irq   = 1'b1;
               state_next = SAVE;
            end
         end
         SAVE:    state_next = VECTOR;
         VECTOR:  state_next = KERNEL;
         KERNEL:  if (eret) state_next = RUN;
         default: state_next = RUN;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= RUN;
         cause_q  <= CAUSE_NONE;
         kernel_q <= 1'b0;
         epc_q    <= '0;
         exc_pc_q <= '0;
      end else begin
         state <= state_next;

         // Resume PC: the faulting instruction is skipped on UNDEF, while an
         // IRQ resumes wherever the core was about to fetch. Wraps mod 2^WIDTH.
         if (take_undef) begin
            epc_q   <= pc_now + WIDTH'(4);
            cause_q <= CAUSE_UNDEF;
         end else if (take_irq) begin
            epc_q   <= pc_next;
            cause_q <= CAUSE_IRQ;
         end

         // Vector is chosen one cycle early so it is stable during VECTOR.
         if (state == SAVE) begin
            exc_pc_q <= (cause_q == CAUSE_IRQ) ? IRQ_VECTOR : EXC_VECTOR;
         end

         if (state == VECTOR) begin
            kernel_q <= 1'b1;
         end else if (state == KERNEL && eret) begin
            kernel_q <= 1'b0;
            cause_q  <= CAUSE_NONE;
         end
      end
   end

   assign cpu_hold     = (state == SAVE) || (state == VECTOR);
   assign epc_write    = (state == SAVE);
   assign irq_ack      = (state == SAVE) && (cause_q == CAUSE_IRQ);
   assign exc_pc_write = (state == VECTOR);
   // Flush is combinational so the decode-cycle instruction never commits;
   // in KERNEL it is the only reaction to an undefined instruction.
   assign flush        = !reset && undef_inst && ((state == RUN) || (state == KERNEL));
   assign epc_data     = epc_q;
   assign exc_pc       = exc_pc_q;
   assign kernel_mode  = kernel_q;
   assign cause        = cause_q;

endmodule

// File: tb/tb_exception_ctrl.sv
// ---------------------------------------------------------------------------
// tb_exception_ctrl
//   Self-checking bench for exception_ctrl: directed scenarios followed by a
//   randomized run, every cycle compared against a behavioural model that
//   tracks kernel mode, the pending IRQ and the position within an entry
//   sequence (cycles since the trigger).
// ---------------------------------------------------------------------------
module tb_exception_ctrl;

   localparam logic [31:0] IRQ_VEC = 32'h8000_0004;
   localparam logic [31:0] EXC_VEC = 32'h8000_0008;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        irq = 1'b0;
   logic        inst_done = 1'b0;
   logic        undef_inst = 1'b0;
   logic        eret = 1'b0;
   logic [31:0] pc_now = '0;
   logic [31:0] pc_next = '0;
   logic        cpu_hold, flush, epc_write, exc_pc_write, kernel_mode, irq_ack;
   logic [31:0] epc_data, exc_pc;
   logic [1:0]  cause;

   int n_vec = 0;
   int n_err = 0;

   // Reference model state.
   bit          m_kernel;
   bit          m_pend;
   int          m_step;    // 0: no entry in progress, 1: save cycle, 2: vector cycle
   int unsigned m_cause;   // 0 none, 1 IRQ, 2 UNDEF
   logic [31:0] m_epc;
   logic [31:0] m_exc_pc;

   exception_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .irq          (irq),
      .inst_done    (inst_done),
      .undef_inst   (undef_inst),
      .pc_now       (pc_now),
      .pc_next      (pc_next),
      .eret         (eret),
      .cpu_hold     (cpu_hold),
      .flush        (flush),
      .epc_write    (epc_write),
      .epc_data     (epc_data),
      .exc_pc_write (exc_pc_write),
      .exc_pc       (exc_pc),
      .kernel_mode  (kernel_mode),
      .cause        (cause),
      .irq_ack      (irq_ack)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_kernel = 1'b0;
      m_pend   = 1'b0;
      m_step   = 0;
      m_cause  = 0;
      m_epc    = '0;
      m_exc_pc = '0;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, " cpu_hold"},     32'(cpu_hold),     32'd0);
      chk({tag, " flush"},        32'(flush),        32'd0);
      chk({tag, " epc_write"},    32'(epc_write),    32'd0);
      chk({tag, " epc_data"},     epc_data,          32'd0);
      chk({tag, " exc_pc_write"}, 32'(exc_pc_write), 32'd0);
      chk({tag, " exc_pc"},       exc_pc,            32'd0);
      chk({tag, " kernel_mode"},  32'(kernel_mode),  32'd0);
      chk({tag, " cause"},        32'(cause),        32'd0);
      chk({tag, " irq_ack"},      32'(irq_ack),      32'd0);
   endtask

   // One clock cycle: drive inputs after the falling edge, compare outputs
   // mid-low-phase, then advance the model across the rising edge.
   task automatic cyc(input bit i_irq, input bit i_done, input bit i_undef, input bit i_eret,
                      input logic [31:0] i_now, input logic [31:0] i_next);
      bit old_pend;
      bit ack;
      @(negedge clk);
      irq        = i_irq;
      inst_done  = i_done;
      undef_inst = i_undef;
      eret       = i_eret;
      pc_now     = i_now;
      pc_next    = i_next;
      #1;
      chk("cpu_hold",     32'(cpu_hold),     32'(m_step != 0));
      chk("epc_write",    32'(epc_write),    32'(m_step == 1));
      chk("irq_ack",      32'(irq_ack),      32'(m_step == 1 && m_cause == 1));
      chk("exc_pc_write", 32'(exc_pc_write), 32'(m_step == 2));
      chk("flush",        32'(flush),        32'(i_undef && m_step == 0));
      chk("kernel_mode",  32'(kernel_mode),  32'(m_kernel));
      chk("cause",        32'(cause),        32'(m_cause));
      if (m_step == 1) chk("epc_data", epc_data, m_epc);
      if (m_step == 2) chk("exc_pc",   exc_pc,   m_exc_pc);
      @(posedge clk);
      ack      = (m_step == 1 && m_cause == 1);
      old_pend = m_pend;
      if (i_irq)    m_pend = 1'b1;
      else if (ack) m_pend = 1'b0;
      if (m_step == 1) begin
         m_exc_pc = (m_cause == 1) ? IRQ_VEC : EXC_VEC;
         m_step   = 2;
      end else if (m_step == 2) begin
         m_kernel = 1'b1;
         m_step   = 0;
      end else if (!m_kernel) begin
         if (i_undef) begin
            m_epc   = i_now + 32'd4;
            m_cause = 2;
            m_step  = 1;
         end else if (i_done && old_pend) begin
            m_epc   = i_next;
            m_cause = 1;
            m_step  = 1;
         end
      end else if (i_eret) begin
         m_kernel = 1'b0;
         m_cause  = 0;
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0040_0000, 32'h0040_0004);
   endtask

   task automatic do_reset();
      @(negedge clk);
      irq = 1'b0; inst_done = 1'b0; undef_inst = 1'b0; eret = 1'b0;
      reset = 1'b1;
      #1;
      check_all_zero("reset");
      model_reset();
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      bit          irq_lvl;
      bit          r_done, r_undef, r_eret;
      logic [31:0] r_now, r_next;

      model_reset();
      do_reset();

      // IRQ raised in user code, taken at the next instruction boundary.
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0040_0008, 32'h0040_000C);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0040_000C, 32'h0040_0010);
      idle(3);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h8000_0010, 32'h0040_0010);
      idle(1);

      // Undefined instruction in user code.
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0040_0020, 32'h0040_0024);
      idle(3);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h8000_0020, 32'h0040_0024);

      // Same-cycle UNDEF and IRQ: UNDEF first, IRQ after eret; an
      // instruction boundary on the eret cycle itself must not take it.
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h0040_0030, 32'h0040_0034);
      idle(3);
      cyc(1'b0, 1'b1, 1'b0, 1'b1, 32'h8000_0030, 32'h0040_0034);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0040_0034, 32'h0040_0038);
      idle(3);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h8000_0040, 32'h0040_0038);

      // IRQ raised while the handler runs stays pending until user code.
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0040_0050, 32'h0040_0054);
      idle(2);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h8000_0050, 32'h8000_0054);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h8000_0054, 32'h8000_0058);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h8000_0058, 32'h0040_0054);
      idle(1);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0040_0054, 32'h0040_0058);
      idle(3);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h8000_0060, 32'h0040_0058);

      // eret in user mode is ignored; undef in kernel mode only flushes.
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h0040_0060, 32'h0040_0064);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0040_0064, 32'h0040_0068);
      idle(3);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h8000_0070, 32'h8000_0074);
      idle(1);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h8000_0074, 32'h0040_0068);

      // Resume PC wraps modulo 2^32.
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0000_0000);
      idle(3);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h8000_0080, 32'h0000_0000);

      // Reset while in the vector cycle aborts the entry.
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0040_0100, 32'h0040_0104);
      idle(1);
      @(negedge clk);
      #1;
      chk("vector cycle before reset", 32'(exc_pc_write), 32'd1);
      reset = 1'b1;
      #1;
      check_all_zero("mid-vector reset");
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      idle(4);

      // Randomized traffic.
      irq_lvl = 1'b0;
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 99) < 8) irq_lvl = ~irq_lvl;
         r_done  = ($urandom_range(0, 3) == 0);
         r_undef = ($urandom_range(0, 19) == 0);
         r_eret  = m_kernel ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 29) == 0);
         if ($urandom_range(0, 15) == 0) r_now = 32'hFFFF_FFFC;
         else                            r_now = $urandom() & 32'hFFFF_FFFC;
         if ($urandom_range(0, 3) == 0)  r_next = $urandom() & 32'hFFFF_FFFC;
         else                            r_next = r_now + 32'd4;
         cyc(irq_lvl, r_done, r_undef, r_eret, r_now, r_next);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
